// File: rtl/parking_pkg.sv
// parking_pkg
//   Shared definitions for the parking-lot gate scheduler and the gate
//   controller it feeds: one-hot scheduler state encodings and the state
//   width constant.
//   Optional feature macro used by the scheduler: PARKING_SCHED_TIMEOUT_EN.
package parking_pkg;

  // Width of the one-hot gate-sequencing state vector (shared with the
  // gate controller).
  localparam int GATE_ST_W = 6;

  typedef logic [GATE_ST_W-1:0] gate_st_t;

  localparam logic [5:0] S_IDLE     = 6'b000001;
  localparam logic [5:0] S_GNT_IN   = 6'b000010;
  localparam logic [5:0] S_PASS_IN  = 6'b000100;
  localparam logic [5:0] S_GNT_OUT  = 6'b001000;
  localparam logic [5:0] S_PASS_OUT = 6'b010000;
  localparam logic [5:0] S_ALARM    = 6'b100000;

  // True while a lane holds the gate (waiting for it to open or for the
  // vehicle to clear).
  function automatic logic is_busy(input gate_st_t s);
    return |(s & (S_GNT_IN | S_PASS_IN | S_GNT_OUT | S_PASS_OUT));
  endfunction

endpackage

// File: rtl/parking_gate_scheduler_occupancy_counter.sv
// occupancy_counter
//   Saturating up/down counter of occupied parking spaces.
//   Ports:
//     clock, reset  - rising-edge clock, synchronous active-low reset
//     inc, dec      - one-cycle count requests
//     count         - current occupancy
//     full, empty   - count == CAPACITY / count == 0 (combinational)
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] count_q, count_d;

  assign full  = (count_q == CNT_W'(CAPACITY));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Increment at CAPACITY is blocked and decrement at zero holds zero.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler
//   Grants the single barrier gate to the entry or exit lane, one at a time,
//   tracks occupancy, refuses entry when the lot is full and (optionally)
//   raises an alarm when a granted transaction stalls.
//   Ports:
//     clock, reset             - rising-edge clock, synchronous active-low reset
//     reqEntrada, reqSalida    - lane requests (level)
//     gateAbierta              - gate-open status from the gate controller
//     gatePaso                 - one-cycle pulse, vehicle cleared the gate
//     gntEntrada, gntSalida    - lane grants (registered state decode)
//     ocupacion, lleno, vacio  - occupancy count and full/empty flags
//     sAlmTimeout              - stalled-transaction alarm
//   Macro PARKING_SCHED_TIMEOUT_EN builds the stall timer and ALARM state;
//   without it sAlmTimeout is tied low and transactions wait indefinitely.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | gate free, arbitrating requests
//   GNT_IN   | entry lane granted, waiting for gate to open
//   PASS_IN  | gate open for entry, waiting for vehicle to clear
//   GNT_OUT  | exit lane granted, waiting for gate to open
//   PASS_OUT | gate open for exit, waiting for vehicle to clear
//   ALARM    | stalled transaction, held until both lanes go quiet
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 200,
  parameter int TO_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reqEntrada,
  input  logic             reqSalida,
  input  logic             gateAbierta,
  input  logic             gatePaso,
  output logic             gntEntrada,
  output logic             gntSalida,
  output logic [CNT_W-1:0] ocupacion,
  output logic             lleno,
  output logic             vacio,
  output logic             sAlmTimeout
);

  if ((2 ** CNT_W) <= CAPACITY) begin : g_bad_cnt_w
    $error("CNT_W too narrow for CAPACITY");
  end
  if ((2 ** TO_W) <= TIMEOUT) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT");
  end

  gate_st_t state_q, state_d;
  logic     prio_q, prio_d;   // 1: exit lane wins the next tie
  logic     occ_inc, occ_dec;
  logic     elig_in;
  logic     busy;
  logic     timeout_hit;

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clock (clock),
    .reset (reset),
    .inc   (occ_inc),
    .dec   (occ_dec),
    .count (ocupacion),
    .full  (lleno),
    .empty (vacio)
  );

  assign elig_in = reqEntrada && !lleno;
  assign busy    = is_busy(state_q);

`ifdef PARKING_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] timer_q, timer_d;

  // Outside GNT_*/PASS_* the timer sits at zero, so it starts from zero
  // on the first grant cycle.
  always_comb begin
    timer_d = '0;
    if (busy) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeout_hit = busy && (timer_q == TO_W'(TIMEOUT - 1));
  assign sAlmTimeout = (state_q == S_ALARM);
`else
  assign timeout_hit = 1'b0;
  assign sAlmTimeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    occ_inc = 1'b0;
    occ_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig_in && (!reqSalida || !prio_q)) begin
          state_d = S_GNT_IN;
          prio_d  = 1'b1;
        end else if (reqSalida) begin
          state_d = S_GNT_OUT;
          prio_d  = 1'b0;
        end
      end
      // An open gate takes precedence over a request dropped in the same cycle.
      S_GNT_IN: begin
        if (timeout_hit)      state_d = S_ALARM;
        else if (gateAbierta) state_d = S_PASS_IN;
        else if (!reqEntrada) state_d = S_IDLE;
      end
      S_GNT_OUT: begin
        if (timeout_hit)      state_d = S_ALARM;
        else if (gateAbierta) state_d = S_PASS_OUT;
        else if (!reqSalida)  state_d = S_IDLE;
      end
      // A completing vehicle beats the timer on the expiry edge.
      S_PASS_IN: begin
        if (gatePaso) begin
          state_d = S_IDLE;
          occ_inc = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ALARM;
        end
      end
      S_PASS_OUT: begin
        if (gatePaso) begin
          state_d = S_IDLE;
          occ_dec = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ALARM;
        end
      end
      S_ALARM: begin
        if (!reqEntrada && !reqSalida) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign gntEntrada = (state_q == S_GNT_IN)  || (state_q == S_PASS_IN);
  assign gntSalida  = (state_q == S_GNT_OUT) || (state_q == S_PASS_OUT);

  a_one_grant : assert property (@(posedge clock) disable iff (!reset)
                                 !(gntEntrada && gntSalida));

endmodule

// File: tb/tb_parking_gate_scheduler.sv
module tb_parking_gate_scheduler;

  localparam int CAPACITY = 16;
  localparam int TIMEOUT  = 200;

  logic       clock       = 1'b0;
  logic       reset       = 1'b0;
  logic       reqEntrada  = 1'b0;
  logic       reqSalida   = 1'b0;
  logic       gateAbierta = 1'b0;
  logic       gatePaso    = 1'b0;
  logic       gntEntrada, gntSalida, lleno, vacio, sAlmTimeout;
  logic [4:0] ocupacion;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  parking_gate_scheduler #(
    .CAPACITY (CAPACITY),
    .CNT_W    (5),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reqEntrada  (reqEntrada),
    .reqSalida   (reqSalida),
    .gateAbierta (gateAbierta),
    .gatePaso    (gatePaso),
    .gntEntrada  (gntEntrada),
    .gntSalida   (gntSalida),
    .ocupacion   (ocupacion),
    .lleno       (lleno),
    .vacio       (vacio),
    .sAlmTimeout (sAlmTimeout)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic expect_outs(input string tag, input int g_in, input int g_out,
                             input int occ, input int alm);
    check({tag, ".gntEntrada"},  int'(gntEntrada),  g_in);
    check({tag, ".gntSalida"},   int'(gntSalida),   g_out);
    check({tag, ".ocupacion"},   int'(ocupacion),   occ);
    check({tag, ".lleno"},       int'(lleno),       int'(occ == CAPACITY));
    check({tag, ".vacio"},       int'(vacio),       int'(occ == 0));
    check({tag, ".sAlmTimeout"}, int'(sAlmTimeout), alm);
  endtask

  // Reference model. phase: 0 gate free, 1 lane granted awaiting the gate,
  // 2 vehicle passing, 3 stall alarm. lane: 0 entry, 1 exit.
  int m_phase = 0;
  int m_lane  = 0;
  int m_occ   = 0;
  int m_age   = 0;
  bit m_prio  = 1'b0;
  bit m_live  = 1'b0;
  bit want_in, stalled, lane_req;

  always @(posedge clock) begin
    if (!reset) begin
      m_phase = 0; m_lane = 0; m_occ = 0; m_age = 0; m_prio = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      if (m_phase == 1 || m_phase == 2) m_age++;
`ifdef PARKING_SCHED_TIMEOUT_EN
      stalled = (m_age >= TIMEOUT);
`else
      stalled = 1'b0;
`endif
      lane_req = (m_lane == 0) ? reqEntrada : reqSalida;
      case (m_phase)
        0: begin
          want_in = reqEntrada && (m_occ < CAPACITY);
          if (want_in || reqSalida) begin
            if (want_in && reqSalida) m_lane = int'(m_prio);
            else                      m_lane = want_in ? 0 : 1;
            m_prio  = (m_lane == 0);
            m_phase = 1;
            m_age   = 0;
          end
        end
        1: begin
          if (stalled)          m_phase = 3;
          else if (gateAbierta) m_phase = 2;
          else if (!lane_req)   m_phase = 0;
        end
        2: begin
          if (gatePaso) begin
            m_phase = 0;
            if (m_lane == 0) m_occ = (m_occ < CAPACITY) ? m_occ + 1 : m_occ;
            else             m_occ = (m_occ > 0) ? m_occ - 1 : 0;
          end else if (stalled) begin
            m_phase = 3;
          end
        end
        default: begin
          if (!reqEntrada && !reqSalida) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      expect_outs("model",
                  int'((m_phase == 1 || m_phase == 2) && m_lane == 0),
                  int'((m_phase == 1 || m_phase == 2) && m_lane == 1),
                  m_occ, int'(m_phase == 3));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic await_grant(input bit lane);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc(1);
      if (lane ? gntSalida : gntEntrada) ok = 1'b1;
    end
    check("grant_seen", int'(ok), 1);
  endtask

  task automatic vehicle(input bit lane, input int gap);
    if (lane) reqSalida = 1'b1; else reqEntrada = 1'b1;
    await_grant(lane);
    cyc(gap);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0;
    gatePaso    = 1'b1;
    if (lane) reqSalida = 1'b0; else reqEntrada = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
  endtask

  initial begin
    int order[3];

    cyc(3);
    reset = 1'b1;
    expect_outs("reset", 0, 0, 0, 0);

    // Entry then exit with literal expectations.
    reqEntrada = 1'b1;
    check("gnt_in_before_edge", int'(gntEntrada), 0);
    cyc(1);
    check("gnt_in_latency", int'(gntEntrada), 1);
    cyc(3);
    gateAbierta = 1'b1;
    cyc(1);
    check("pass_in_gnt_held", int'(gntEntrada), 1);
    gateAbierta = 1'b0; gatePaso = 1'b1; reqEntrada = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    expect_outs("after_entry", 0, 0, 1, 0);
    reqSalida = 1'b1;
    cyc(1);
    check("gnt_out_after_idle", int'(gntSalida), 1);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0; gatePaso = 1'b1; reqSalida = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    expect_outs("after_exit", 0, 0, 0, 0);

    // Three rounds with both lanes held: entry, exit, entry.
    reqEntrada = 1'b1; reqSalida = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc(1);
      order[r] = gntSalida ? 1 : (gntEntrada ? 0 : -1);
      gateAbierta = 1'b1;
      cyc(1);
      gateAbierta = 1'b0; gatePaso = 1'b1;
      cyc(1);
      gatePaso = 1'b0;
    end
    reqEntrada = 1'b0; reqSalida = 1'b0;
    check("tie_round0", order[0], 0);
    check("tie_round1", order[1], 1);
    check("tie_round2", order[2], 0);
    check("tie_occ", int'(ocupacion), 1);

    // Fill the lot, then hold entry while full.
    for (int i = 0; i < 15; i++) vehicle(1'b0, i % 3);
    expect_outs("full", 0, 0, 16, 0);
    reqEntrada = 1'b1;
    cyc(50);
    check("full_entry_refused", int'(gntEntrada), 0);
    check("full_lleno", int'(lleno), 1);
    reqSalida = 1'b1;
    cyc(1);
    check("full_exit_granted", int'(gntSalida), 1);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0; gatePaso = 1'b1; reqSalida = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    check("full_exit_occ", int'(ocupacion), 15);
    cyc(1);
    check("entry_after_exit", int'(gntEntrada), 1);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0; gatePaso = 1'b1; reqEntrada = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    check("refill_occ", int'(ocupacion), 16);

    // Drain, then an exit at zero holds zero.
    for (int i = 0; i < 16; i++) vehicle(1'b1, 1);
    expect_outs("drained", 0, 0, 0, 0);
    vehicle(1'b1, 0);
    check("dec_at_zero", int'(ocupacion), 0);

    // Request withdrawn before the gate opens.
    vehicle(1'b0, 0);
    reqEntrada = 1'b1;
    cyc(1);
    check("withdraw_granted", int'(gntEntrada), 1);
    reqEntrada = 1'b0;
    cyc(1);
    expect_outs("withdrawn", 0, 0, 1, 0);

`ifdef PARKING_SCHED_TIMEOUT_EN
    reqEntrada = 1'b1;
    cyc(1);
    cyc(199);
    check("pre_expiry_gnt", int'(gntEntrada), 1);
    check("pre_expiry_alarm", int'(sAlmTimeout), 0);
    cyc(1);
    expect_outs("alarm", 0, 0, 1, 1);
    cyc(10);
    reqSalida = 1'b1;
    cyc(5);
    reqEntrada = 1'b0;
    cyc(3);
    check("alarm_held_one_req", int'(sAlmTimeout), 1);
    reqSalida = 1'b0;
    cyc(1);
    expect_outs("alarm_cleared", 0, 0, 1, 0);
    // gatePaso on the expiry edge completes normally.
    reqEntrada = 1'b1;
    cyc(1);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0;
    cyc(198);
    check("expiry_edge_gnt", int'(gntEntrada), 1);
    gatePaso = 1'b1; reqEntrada = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    expect_outs("expiry_paso", 0, 0, 2, 0);
`else
    reqEntrada = 1'b1;
    cyc(1);
    cyc(300);
    check("no_timeout_gnt", int'(gntEntrada), 1);
    check("no_timeout_alarm", int'(sAlmTimeout), 0);
    gateAbierta = 1'b1;
    cyc(1);
    gateAbierta = 1'b0; gatePaso = 1'b1; reqEntrada = 1'b0;
    cyc(1);
    gatePaso = 1'b0;
    expect_outs("no_timeout_done", 0, 0, 2, 0);
`endif

    // Reset in the middle of PASS_OUT.
    reqSalida = 1'b1;
    cyc(1);
    gateAbierta = 1'b1;
    cyc(1);
    check("pass_out_gnt", int'(gntSalida), 1);
    gateAbierta = 1'b0; reqSalida = 1'b0; reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    expect_outs("mid_reset", 0, 0, 0, 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      reqEntrada  = ($urandom_range(99) < 60);
      reqSalida   = ($urandom_range(99) < 35);
      gateAbierta = ($urandom_range(99) < 30);
      gatePaso    = ($urandom_range(99) < 25);
      reset       = ($urandom_range(999) != 0);
      cyc(1);
    end
    reqEntrada = 1'b0; reqSalida = 1'b0; gateAbierta = 1'b0; gatePaso = 1'b0;
    reset = 1'b1;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
